// File: rtl/bpuf_eval_ctrl.sv
// Evaluation controller for a bistable-ring PUF array: excite, settle, sample, repeat N_EVAL times, majority vote.
// Optional per-cell instability mask when BPUF_STABILITY_MASK_EN is defined.
module bpuf_eval_ctrl #(
    parameter int unsigned N_CELLS    = 16,
    parameter int unsigned EXCITE_CYC = 4,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned N_EVAL     = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [N_CELLS-1:0] challenge,
    input  logic [N_CELLS-1:0] cell_q,
    output logic [N_CELLS-1:0] excite,
    output logic               busy,
    output logic               resp_valid,
    output logic [N_CELLS-1:0] response,
    output logic [N_CELLS-1:0] unstable
);

    localparam int unsigned CW   = $clog2(N_EVAL + 1);
    localparam int unsigned MAXC = (EXCITE_CYC > SETTLE_CYC) ? EXCITE_CYC : SETTLE_CYC;
    localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXCITE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [TW-1:0]      cyc_cnt, cyc_nxt;
    logic [CW-1:0]      eval_cnt, eval_nxt;
    logic [N_CELLS-1:0] chal_q, chal_nxt;
    logic [N_CELLS-1:0] sync1, sync_q;
    logic [CW-1:0]      ones_cnt [N_CELLS];
    logic [CW-1:0]      ones_nxt [N_CELLS];
    logic [N_CELLS-1:0] excite_nxt;
    logic               busy_nxt;
    logic               resp_valid_nxt;
    logic [N_CELLS-1:0] response_nxt;
`ifdef BPUF_STABILITY_MASK_EN
    logic [N_CELLS-1:0] unstable_q, unstable_nxt;
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_nxt      = state;
        cyc_nxt        = cyc_cnt;
        eval_nxt       = eval_cnt;
        chal_nxt       = chal_q;
        ones_nxt       = ones_cnt;
        resp_valid_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    chal_nxt  = challenge;
                    eval_nxt  = '0;
                    cyc_nxt   = '0;
                    state_nxt = S_EXCITE;
                    for (int i = 0; i < int'(N_CELLS); i++) begin
                        ones_nxt[i] = '0;
                    end
                end
            end
            S_EXCITE: begin
                if (cyc_cnt == TW'(EXCITE_CYC - 1)) begin
                    cyc_nxt   = '0;
                    state_nxt = S_SETTLE;
                end else begin
                    cyc_nxt = cyc_cnt + TW'(1);
                end
            end
            S_SETTLE: begin
                if (cyc_cnt == TW'(SETTLE_CYC - 1)) begin
                    cyc_nxt   = '0;
                    state_nxt = S_SAMPLE;
                end else begin
                    cyc_nxt = cyc_cnt + TW'(1);
                end
            end
            S_SAMPLE: begin
                for (int i = 0; i < int'(N_CELLS); i++) begin
                    if (chal_q[i]) begin
                        ones_nxt[i] = ones_cnt[i] + CW'(sync_q[i]);
                    end
                end
                eval_nxt = eval_cnt + CW'(1);
                if (eval_cnt == CW'(N_EVAL - 1)) begin
                    resp_valid_nxt = 1'b1;
                    state_nxt      = S_DONE;
                end else begin
                    state_nxt = S_EXCITE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything; the response registers stay untouched
        if (abort && (state != S_IDLE)) begin
            state_nxt      = S_IDLE;
            resp_valid_nxt = 1'b0;
        end

        excite_nxt = (state_nxt == S_EXCITE) ? chal_nxt : '0;
        busy_nxt   = (state_nxt != S_IDLE);

        for (int i = 0; i < int'(N_CELLS); i++) begin
            response_nxt[i] = chal_q[i] & (ones_nxt[i] > CW'(N_EVAL / 2));
        end
`ifdef BPUF_STABILITY_MASK_EN
        for (int i = 0; i < int'(N_CELLS); i++) begin
            unstable_nxt[i] = chal_q[i] & (ones_nxt[i] != '0) & (ones_nxt[i] != CW'(N_EVAL));
        end
`endif
    end

    // State, counters, synchroniser and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cyc_cnt    <= '0;
            eval_cnt   <= '0;
            chal_q     <= '0;
            sync1      <= '0;
            sync_q     <= '0;
            excite     <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            response   <= '0;
            for (int i = 0; i < int'(N_CELLS); i++) begin
                ones_cnt[i] <= '0;
            end
`ifdef BPUF_STABILITY_MASK_EN
            unstable_q <= '0;
`endif
        end else begin
            state      <= state_nxt;
            cyc_cnt    <= cyc_nxt;
            eval_cnt   <= eval_nxt;
            chal_q     <= chal_nxt;
            sync1      <= cell_q;
            sync_q     <= sync1;
            excite     <= excite_nxt;
            busy       <= busy_nxt;
            resp_valid <= resp_valid_nxt;
            ones_cnt   <= ones_nxt;
            if (resp_valid_nxt) begin
                response <= response_nxt;
`ifdef BPUF_STABILITY_MASK_EN
                unstable_q <= unstable_nxt;
`endif
            end
        end
    end

`ifdef BPUF_STABILITY_MASK_EN
    assign unstable = unstable_q;
`else
    assign unstable = '0;
`endif

endmodule

// File: tb/tb_bpuf_eval_ctrl.sv
// Scoreboard bench for bpuf_eval_ctrl: default instance plus a minimal N_EVAL=1 instance.
module tb_bpuf_eval_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort;
    logic [15:0] challenge, cell_q, excite, response, unstable;
    logic        busy, resp_valid;

    logic        start1, abort1;
    logic [15:0] challenge1, cell_q1, excite1, response1, unstable1;
    logic        busy1, resp_valid1;

    bpuf_eval_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .challenge(challenge), .cell_q(cell_q), .excite(excite), .busy(busy),
        .resp_valid(resp_valid), .response(response), .unstable(unstable)
    );

    bpuf_eval_ctrl #(.N_CELLS(16), .EXCITE_CYC(1), .SETTLE_CYC(2), .N_EVAL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .challenge(challenge1), .cell_q(cell_q1), .excite(excite1), .busy(busy1),
        .resp_valid(resp_valid1), .response(response1), .unstable(unstable1)
    );

`ifdef BPUF_STABILITY_MASK_EN
    localparam logic [15:0] U_ALT = 16'h0001;
`else
    localparam logic [15:0] U_ALT = 16'h0000;
`endif

    typedef struct {
        logic [15:0] resp;
        logic [15:0] unst;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] chal, input bit push, input logic [15:0] er,
                         input logic [15:0] eu, output int t);
        start     = 1'b1;
        challenge = chal;
        t         = cyc;
        if (push) q0.push_back('{resp: er, unst: eu, cyc: t + 106});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitors: pop expectation on every resp_valid
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (q0.size() == 0) begin
                chk("dut_unexpected_resp_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("dut_response", response, e.resp);
                chk("dut_unstable", unstable, e.unst);
                chk("dut_resp_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (resp_valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_resp_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_response", response1, e.resp);
                chk("dut1_unstable", unstable1, e.unst);
                chk("dut1_resp_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int t0, t1;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; challenge = '0; cell_q = '0;
        start1 = 1'b0; abort1 = 1'b0; challenge1 = '0; cell_q1 = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("rst_excite", excite, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_response", response, 0);
        chk("rst_unstable", unstable, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Constant pattern, all cells enabled
        cell_q = 16'hA5A5;
        issue(16'hFFFF, 1'b1, 16'hA5A5, 16'h0000, t0);
        wait_cyc(t0 + 1);
        chk("t1_busy_c1", busy, 1);
        chk("t1_excite_c1", excite, 16'hFFFF);
        wait_cyc(t0 + 107);
        chk("t1_busy_after", busy, 0);

        // Partial challenge masks excite and response
        cell_q = 16'hFFFF;
        issue(16'h00FF, 1'b1, 16'h00FF, 16'h0000, t0);
        for (int i = 1; i <= 4; i++) begin
            wait_cyc(t0 + i);
            chk("t2_excite_on", excite, 16'h00FF);
        end
        wait_cyc(t0 + 5);
        chk("t2_excite_off", excite, 16'h0000);
        wait_cyc(t0 + 107);

        // Cell 0 alternates 1,0,1,0,1 across evaluations
        cell_q = 16'h3C01;
        issue(16'hFFFF, 1'b1, 16'h3C01, U_ALT, t0);
        for (int k = 0; k < 5; k++) begin
            wait_cyc(t0 + 21 * k + 8);
            cell_q[0] = (k % 2 == 0);
        end
        wait_cyc(t0 + 107);

        // Abort mid-run, then immediate restart
        cell_q = 16'hA5A5;
        issue(16'hFFFF, 1'b0, 16'h0000, 16'h0000, t0);
        wait_cyc(t0 + 30);
        abort = 1'b1;
        wait_cyc(t0 + 31);
        abort = 1'b0;
        chk("t4_abort_excite", excite, 0);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_resp_valid", resp_valid, 0);
        chk("t4_abort_response_kept", response, 16'h3C01);
        wait_cyc(t0 + 32);
        issue(16'hFFFF, 1'b1, 16'hA5A5, 16'h0000, t1);
        chk("t4_restart_busy", busy, 1);
        wait_cyc(t1 + 107);

        // Start while busy is ignored
        cell_q = 16'h0F0F;
        issue(16'hFFFF, 1'b1, 16'h0F0F, 16'h0000, t0);
        wait_cyc(t0 + 10);
        start = 1'b1; challenge = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(t0 + 107);
        chk("t5_busy_after", busy, 0);

        // Reset mid-operation
        issue(16'hFFFF, 1'b0, 16'h0000, 16'h0000, t0);
        wait_cyc(t0 + 50);
        rst_n = 1'b0;
        wait_cyc(t0 + 51);
        rst_n = 1'b1;
        chk("t6_rst_excite", excite, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_resp_valid", resp_valid, 0);
        chk("t6_rst_response", response, 0);
        chk("t6_rst_unstable", unstable, 0);
        wait_cyc(t0 + 120);

        // Minimal configuration: N_EVAL=1, EXCITE_CYC=1, SETTLE_CYC=2
        start1 = 1'b1; challenge1 = 16'h5A3C; t0 = cyc;
        q1.push_back('{resp: 16'h5A3C, unst: 16'h0000, cyc: t0 + 5});
        @(negedge clk);
        start1 = 1'b0;
        chk("t7_excite1_on", excite1, 16'h5A3C);
        wait_cyc(t0 + 2);
        chk("t7_excite1_off", excite1, 16'h0000);
        wait_cyc(t0 + 8);
        chk("t7_busy1_after", busy1, 0);

        for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
